mac_vec: RTL and testbench

- Parametrised, pipelined multi-lane signed multiply-accumulate engine for the GEMM datapath.
- Each beat presents one operand pair per lane. Lanes accumulate independently until a beat flagged last.
- That beat's completed dot products move to a held output register with valid/ready handshake.
- Accumulators restart automatically for the next dot product.

---
 rtl/mac_vec.sv | 197 +++++++++++++++++++
 tb/tb_mac_vec.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_vec.sv
// Multi-lane pipelined signed MAC: a multiply stage, then an accumulate stage feeding a held valid/ready result.
// Optional clamping arithmetic with per-lane sticky flags is enabled by defining MAC_SAT_EN.

module mac_vec_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     mul_en_i,
    input  logic                     acc_en_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  res_o,
    output logic                     sat_o
);

    logic signed [2*DATA_W-1:0] prod_q;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_base;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    res_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_q <= '0;
        end else if (mul_en_i) begin
            prod_q <= a_i * b_i;
        end
    end

    assign prod_ext = ACC_W'(prod_q);
    // The first term of a dot product ignores whatever the accumulator holds.
    assign acc_base = first_i ? '0 : acc_q;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_w;
    logic                  ovf;
    logic                  sat_q;
    logic                  sat_d;
    logic                  res_sat_q;

    always_comb begin
        sum_w = (ACC_W+1)'(acc_base) + (ACC_W+1)'(prod_ext);
        // One guard bit suffices: overflow shows as a mismatch of the top two bits.
        ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        if (!ovf) begin
            sum = sum_w[ACC_W-1:0];
        end else if (sum_w[ACC_W]) begin
            sum = ACC_MIN;
        end else begin
            sum = ACC_MAX;
        end
        sat_d = (first_i ? 1'b0 : sat_q) | ovf;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_q     <= 1'b0;
            res_sat_q <= 1'b0;
        end else if (clear_i) begin
            sat_q     <= 1'b0;
        end else if (acc_en_i) begin
            if (last_i) begin
                res_sat_q <= sat_d;
                sat_q     <= 1'b0;
            end else begin
                sat_q     <= sat_d;
            end
        end
    end

    assign sat_o = res_sat_q;
`else
    assign sum   = acc_base + prod_ext;
    assign sat_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            res_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            if (last_i) begin
                res_q <= sum;
                acc_q <= '0;
            end else begin
                acc_q <= sum;
            end
        end
    end

    assign res_o = res_q;

endmodule

module mac_vec #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [LANES*DATA_W-1:0]   a_in,
    input  logic [LANES*DATA_W-1:0]   b_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ACC_W-1:0]    acc_out,
    output logic [LANES-1:0]          sat_out
);

    logic stall;
    logic mul_en;
    logic acc_en;
    logic ld_res;
    logic p_valid_q, p_valid_d;
    logic p_last_q;
    logic first_q;
    logic out_valid_q, out_valid_d;

    // A held, unaccepted result freezes both stages so nothing overwrites it.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;
    assign mul_en   = in_valid & ~stall & ~clear;
    assign acc_en   = p_valid_q & ~stall & ~clear;
    assign ld_res   = acc_en & p_last_q;

    always_comb begin
        p_valid_d = p_valid_q;
        if (clear) begin
            p_valid_d = 1'b0;
        end else if (!stall) begin
            p_valid_d = in_valid;
        end
        out_valid_d = out_valid_q;
        if (ld_res) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            p_valid_q   <= p_valid_d;
            out_valid_q <= out_valid_d;
            if (mul_en) begin
                p_last_q <= in_last;
            end
            if (clear) begin
                first_q <= 1'b1;
            end else if (acc_en) begin
                first_q <= p_last_q;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_vec_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk_i    (clk),
            .rst_i    (rst),
            .clear_i  (clear),
            .mul_en_i (mul_en),
            .acc_en_i (acc_en),
            .first_i  (first_q),
            .last_i   (p_last_q),
            .a_i      (a_in[i*DATA_W +: DATA_W]),
            .b_i      (b_in[i*DATA_W +: DATA_W]),
            .res_o    (acc_out[i*ACC_W +: ACC_W]),
            .sat_o    (sat_out[i])
        );
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_vec.sv
// Directed bench for mac_vec: single-beat vector table plus sequences for
// back-to-back, backpressure, clear and overflow behaviour.
module tb_mac_vec;
    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int AW    = 19;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [LANES*DW-1:0]   a_in;
    logic [LANES*DW-1:0]   b_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*AW-1:0]   acc_out;
    logic [LANES-1:0]      sat_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mac_vec #(.LANES(LANES), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .sat_out   (sat_out)
    );

    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][18:0] e;
    } vec_t;

    vec_t tv[4];

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint lane(input int i);
        logic signed [AW-1:0] v;
        v = acc_out[i*AW +: AW];
        return longint'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        a_in     = a;
        b_in     = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    initial begin
        // lanes listed 3..0 in each concatenation
        tv[0].a = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
        tv[0].b = {8'sd8, 8'sd7, 8'sd6, 8'sd5};
        tv[0].e = {19'sd32, 19'sd21, 19'sd12, 19'sd5};
        tv[1].a = {8'sd0, 8'sd127, 8'h80, -8'sd1};
        tv[1].b = {8'sd55, 8'sd127, 8'h80, 8'sd1};
        tv[1].e = {19'sd0, 19'sd16129, 19'sd16384, -19'sd1};
        tv[2].a = {8'sd100, -8'sd7, 8'sd127, 8'h80};
        tv[2].b = {-8'sd100, 8'sd9, 8'h80, 8'sd127};
        tv[2].e = {-19'sd10000, -19'sd63, -19'sd16256, -19'sd16256};
        tv[3].a = {-8'sd3, 8'sd0, 8'h80, 8'sd127};
        tv[3].b = {-8'sd3, -8'sd5, 8'sd127, 8'sd127};
        tv[3].e = {19'sd9, 19'sd0, -19'sd16256, 19'sd16129};

        // Reset held two cycles with a beat offered
        rst = 1'b1; clear = 1'b0; out_ready = 1'b1;
        beat(32'h04030201, 32'h08070605, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst out_valid", out_valid, 0);
            chk("rst acc_out", longint'(acc_out), 0);
            chk("rst sat_out", sat_out, 0);
        end
        rst = 1'b0;
        idle();
        #1;
        chk("post-rst in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post-rst no result", out_valid, 0);
        end

        // Single-term dot products from the table
        for (int v = 0; v < 4; v++) begin
            beat(tv[v].a, tv[v].b, 1'b1);
            step();
            idle();
            chk("vec t+1 out_valid", out_valid, 0);
            step();
            chk("vec t+2 out_valid", out_valid, 1);
            for (int i = 0; i < LANES; i++)
                chk($sformatf("vec%0d lane%0d", v, i), lane(i), longint'($signed(tv[v].e[i])));
            chk("vec sat_out", sat_out, 0);
            step();
            chk("vec one-cycle valid", out_valid, 0);
        end

        // Three-term then one-term, back to back
        beat(32'h80, 32'h80, 1'b0); step();
        beat(32'h80, 32'h80, 1'b0); step();
        beat(32'h80, 32'h80, 1'b1); step();
        beat(32'h03, 32'hFE, 1'b1); step();
        idle();
        chk("b2b first valid", out_valid, 1);
        chk("b2b first lane0", lane(0), 49152);
        step();
        chk("b2b second valid", out_valid, 1);
        chk("b2b second lane0", lane(0), -6);
        step();
        chk("b2b drained", out_valid, 0);

        // Backpressure with further beats offered
        out_ready = 1'b0;
        beat(32'h02, 32'h03, 1'b1); step();
        beat(32'h04, 32'h05, 1'b0); step();
        beat(32'h01, 32'h01, 1'b1);
        chk("bp held valid", out_valid, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp in_ready low", in_ready, 0);
            chk("bp lane0 stable", lane(0), 6);
            step();
            chk("bp still valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready release", in_ready, 1);
        step();
        idle();
        chk("bp transferred", out_valid, 0);
        step();
        chk("bp pending valid", out_valid, 1);
        chk("bp pending lane0", lane(0), 21);
        step();
        chk("bp drained", out_valid, 0);

        // Clear mid dot product; beat offered with clear is dropped
        beat(32'h0A, 32'h0A, 1'b0); step();
        beat(32'h0A, 32'h0A, 1'b0); step();
        clear = 1'b1;
        beat(32'h07, 32'h07, 1'b1);
        #1;
        chk("clr in_ready", in_ready, 1);
        step();
        clear = 1'b0;
        beat(32'h01, 32'h01, 1'b1);
        chk("clr no output", out_valid, 0);
        step();
        idle();
        chk("clr beat dropped", out_valid, 0);
        step();
        chk("clr result valid", out_valid, 1);
        chk("clr result lane0", lane(0), 1);
        step();

        // Overflow: 17 x 16384
        for (int k = 1; k <= 17; k++) begin
            beat(32'h80, 32'h80, k == 17);
            step();
        end
        idle();
        step();
        chk("ovf valid", out_valid, 1);
`ifdef MAC_SAT_EN
        chk("ovf lane0", lane(0), 262143);
        chk("ovf sat_out", sat_out, 4'b0001);
`else
        chk("ovf lane0", lane(0), -245760);
        chk("ovf sat_out", sat_out, 0);
`endif
        step();
        beat(32'h01, 32'h01, 1'b1); step();
        idle(); step();
        chk("post-ovf valid", out_valid, 1);
        chk("post-ovf lane0", lane(0), 1);
        chk("post-ovf sat cleared", sat_out, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
